// File: rtl/csr_file.sv
// Machine-mode CSR file: execute and interrupt-controller access ports, trap-state exports and a 64-bit cycle counter.
// Optional CSR_MINSTRET_EN adds the 64-bit minstret/minstreth retired-instruction counter.
module csr_file #(
    parameter logic [31:0] MTVEC_RST   = 32'h0000_0000,
    parameter logic [31:0] MSTATUS_RST = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [31:0] raddr_i,
    input  logic [31:0] waddr_i,
    input  logic [31:0] data_i,
    input  logic        inst_retire_i,
    input  logic        clint_we_i,
    input  logic [31:0] clint_raddr_i,
    input  logic [31:0] clint_waddr_i,
    input  logic [31:0] clint_data_i,
    output logic [31:0] data_o,
    output logic [31:0] clint_data_o,
    output logic [31:0] clint_csr_mtvec,
    output logic [31:0] clint_csr_mepc,
    output logic [31:0] clint_csr_mstatus,
    output logic        global_int_en_o
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH  = 12'hB80;
    localparam logic [11:0] ADDR_CYCLE    = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH   = 12'hC80;
`ifdef CSR_MINSTRET_EN
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
`endif

    logic [31:0] mstatus, mie, mtvec, mscratch, mepc, mcause;
    logic [63:0] mcycle;
`ifdef CSR_MINSTRET_EN
    logic [63:0] minstret;
`endif

    logic [11:0] raddr, waddr, clint_raddr, clint_waddr;
    logic        sel_we;
    logic [11:0] sel_addr;
    logic [31:0] sel_data;
    logic        wr_mcycle, wr_mcycleh;

    assign raddr       = raddr_i[11:0];
    assign waddr       = waddr_i[11:0];
    assign clint_raddr = clint_raddr_i[11:0];
    assign clint_waddr = clint_waddr_i[11:0];

    // The execute port owns the single write path; a simultaneous controller write is dropped.
    always_comb begin
        sel_we   = we_i | clint_we_i;
        sel_addr = we_i ? waddr : clint_waddr;
        sel_data = we_i ? data_i : clint_data_i;
    end

    assign wr_mcycle  = sel_we && (sel_addr == ADDR_MCYCLE);
    assign wr_mcycleh = sel_we && (sel_addr == ADDR_MCYCLEH);

    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus  <= MSTATUS_RST;
            mie      <= 32'h0;
            mtvec    <= MTVEC_RST;
            mscratch <= 32'h0;
            mepc     <= 32'h0;
            mcause   <= 32'h0;
            mcycle   <= 64'h0;
        end else begin
            if (sel_we) begin
                case (sel_addr)
                    ADDR_MSTATUS:  mstatus  <= sel_data;
                    ADDR_MIE:      mie      <= sel_data;
                    ADDR_MTVEC:    mtvec    <= sel_data;
                    ADDR_MSCRATCH: mscratch <= sel_data;
                    ADDR_MEPC:     mepc     <= sel_data;
                    ADDR_MCAUSE:   mcause   <= sel_data;
                    default: ;
                endcase
            end
            // A write to either half freezes the whole counter for that cycle.
            if (wr_mcycle)
                mcycle[31:0] <= sel_data;
            else if (wr_mcycleh)
                mcycle[63:32] <= sel_data;
            else
                mcycle <= mcycle + 64'd1;
        end
    end

`ifdef CSR_MINSTRET_EN
    logic wr_minstret, wr_minstreth;

    assign wr_minstret  = sel_we && (sel_addr == ADDR_MINSTRET);
    assign wr_minstreth = sel_we && (sel_addr == ADDR_MINSTRETH);

    always_ff @(posedge clk) begin
        if (rst)
            minstret <= 64'h0;
        else if (wr_minstret)
            minstret[31:0] <= sel_data;
        else if (wr_minstreth)
            minstret[63:32] <= sel_data;
        else if (inst_retire_i)
            minstret <= minstret + 64'd1;
    end
`endif

    function automatic logic [31:0] csr_read(input logic [11:0] addr);
        case (addr)
            ADDR_MSTATUS:              csr_read = mstatus;
            ADDR_MIE:                  csr_read = mie;
            ADDR_MTVEC:                csr_read = mtvec;
            ADDR_MSCRATCH:             csr_read = mscratch;
            ADDR_MEPC:                 csr_read = mepc;
            ADDR_MCAUSE:               csr_read = mcause;
            ADDR_MCYCLE, ADDR_CYCLE:   csr_read = mcycle[31:0];
            ADDR_MCYCLEH, ADDR_CYCLEH: csr_read = mcycle[63:32];
`ifdef CSR_MINSTRET_EN
            ADDR_MINSTRET, ADDR_INSTRET:   csr_read = minstret[31:0];
            ADDR_MINSTRETH, ADDR_INSTRETH: csr_read = minstret[63:32];
`endif
            default:                   csr_read = 32'h0;
        endcase
    endfunction

    // Each port forwards only its own pending write.
    always_comb begin
        data_o = csr_read(raddr);
        if (we_i && (waddr == raddr))
            data_o = data_i;
        clint_data_o = csr_read(clint_raddr);
        if (clint_we_i && (clint_waddr == clint_raddr))
            clint_data_o = clint_data_i;
    end

    assign clint_csr_mtvec   = mtvec;
    assign clint_csr_mepc    = mepc;
    assign clint_csr_mstatus = mstatus;
    assign global_int_en_o   = mstatus[3];

    logic unused_bits;
`ifdef CSR_MINSTRET_EN
    assign unused_bits = ^{raddr_i[31:12], waddr_i[31:12], clint_raddr_i[31:12], clint_waddr_i[31:12]};
`else
    assign unused_bits = ^{raddr_i[31:12], waddr_i[31:12], clint_raddr_i[31:12], clint_waddr_i[31:12],
                           inst_retire_i};
`endif

endmodule
